sensor_emu359: RTL and testbench

SENSOR_EMU359 -- requirements
Module: sensor_emu359

---
 rtl/sensor_emu359.sv | 154 +++++++++++++++
 tb/tb_sensor_emu359.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_emu359.sv
// Image sensor timing emulator: programmable blanking, active window and test patterns,
// with single-shot or continuous frame generation.
module sensor_emu359 #(
   parameter int unsigned DW = 12,
   parameter int unsigned CW = 12
) (
   input  logic          iclk,
   input  logic          rst,
   input  logic          en,
   input  logic          single,
   input  logic [CW-1:0] npix,
   input  logic [CW-1:0] nlines,
   input  logic [7:0]    vb,
   input  logic [7:0]    hb0,
   input  logic [7:0]    hb1,
   input  logic [1:0]    mode,
   output logic          hact,
   output logic          vact,
   output logic [DW-1:0] dout,
   output logic          frame_start,
   output logic          frame_done,
   output logic          busy,
   output logic [15:0]   frame_cnt
);
   localparam int unsigned SW = CW + 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic          en_d;
   logic [CW-1:0] s_npix, s_nlines;
   logic [7:0]    s_vb, s_hb0, s_hb1;
   logic [1:0]    s_mode;
   logic [SW-1:0] pix_q, line_q, pix_d, line_d;
   logic [DW-1:0] dcnt_q, dcnt_inc, pat;
   logic [SW-1:0] line_len, frame_len, act_end;
   logic [5:0]    act_line6, act_pix6;
   logic          run, start, cfg_ok, load, last_pix, last_line, done, is_vact, is_hact;

   // Geometry of the frame currently held in the shadow registers
   always_comb begin
      line_len  = SW'(s_hb0) + SW'(s_npix) + SW'(s_hb1);
      frame_len = SW'(s_vb) + SW'(s_nlines);
      act_end   = SW'(s_hb0) + SW'(s_npix);
   end

   // Next-state and counter advance; a new frame is qualified on the live inputs it will load
   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      line_d    = line_q;
      load      = 1'b0;
      run       = (state_q == RUN);
      start     = single ? (en & ~en_d) : en;
      cfg_ok    = (npix != '0) && (nlines != '0);
      last_pix  = (pix_q == line_len - SW'(1));
      last_line = (line_q == frame_len - SW'(1));
      done      = run && last_pix && last_line;
      case (state_q)
         IDLE: begin
            if (start && cfg_ok) begin
               state_d = RUN;
               load    = 1'b1;
               pix_d   = '0;
               line_d  = '0;
            end
         end
         RUN: begin
            if (last_pix) begin
               pix_d = '0;
               if (last_line) begin
                  line_d = '0;
                  if (start && cfg_ok) load = 1'b1;
                  else state_d = IDLE;
               end else begin
                  line_d = line_q + SW'(1);
               end
            end else begin
               pix_d = pix_q + SW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Window decode and pattern generation for the position held in the counters
   always_comb begin
      is_vact   = run && (line_q >= SW'(s_vb));
      is_hact   = is_vact && (pix_q >= SW'(s_hb0)) && (pix_q < act_end);
      act_line6 = 6'(line_q - SW'(s_vb));
      act_pix6  = 6'(pix_q - SW'(s_hb0));
      dcnt_inc  = dcnt_q + DW'(1);
      pat       = '0;
      if (is_hact) begin
         case (s_mode)
            2'd0:    pat = dcnt_inc;
            2'd1:    pat = DW'({act_line6, act_pix6});
            2'd2:    pat = DW'(12'hA5A);
            default: pat = ~dcnt_inc;
         endcase
      end
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         state_q  <= IDLE;
         pix_q    <= '0;
         line_q   <= '0;
         en_d     <= 1'b0;
         s_npix   <= '0;
         s_nlines <= '0;
         s_vb     <= '0;
         s_hb0    <= '0;
         s_hb1    <= '0;
         s_mode   <= '0;
         dcnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         en_d    <= en;
         if (load) begin
            s_npix   <= npix;
            s_nlines <= nlines;
            s_vb     <= vb;
            s_hb0    <= hb0;
            s_hb1    <= hb1;
            s_mode   <= mode;
         end
         if (is_hact && ((s_mode == 2'd0) || (s_mode == 2'd3))) dcnt_q <= dcnt_inc;
      end
   end

   // Output stage: one cycle behind the counters
   always_ff @(posedge iclk) begin
      if (rst) begin
         hact        <= 1'b0;
         vact        <= 1'b0;
         dout        <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         hact        <= is_hact;
         vact        <= is_vact;
         dout        <= pat;
         frame_start <= run && (pix_q == '0) && (line_q == '0);
         frame_done  <= done;
         busy        <= run;
         if (done) frame_cnt <= frame_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_sensor_emu359.sv
// Randomized scoreboard bench for sensor_emu359: per-frame expectations from a pixel-loop model.
module tb_sensor_emu359;
   logic        iclk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        single = 1'b0;
   logic [11:0] npix = '0, nlines = '0;
   logic [7:0]  vb = '0, hb0 = '0, hb1 = '0;
   logic [1:0]  mode = '0;
   logic        hact, vact, frame_start, frame_done, busy;
   logic [11:0] dout;
   logic [15:0] frame_cnt;

   sensor_emu359 #(.DW(12), .CW(12)) dut (
      .iclk(iclk), .rst(rst), .en(en), .single(single), .npix(npix), .nlines(nlines),
      .vb(vb), .hb0(hb0), .hb1(hb1), .mode(mode), .hact(hact), .vact(vact), .dout(dout),
      .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 iclk = ~iclk;

   typedef struct {int npix; int nlines; int vb; int hb0; int hb1; int mode;} cfg_t;
   typedef struct packed {
      logic hact; logic vact; logic [11:0] dout; logic fs; logic fd; logic busy; logic [15:0] fcnt;
   } exp_t;

   exp_t        sb[$];
   cfg_t        plan[$];
   int          n_chk = 0, n_fail = 0;
   logic [11:0] mdcnt = '0;
   logic [15:0] mfcnt = '0;
   logic [15:0] idle_fcnt = '0;
   logic        rst_s = 1'b1;

   task automatic cmp(input string nm, input logic [32:0] got, input logic [32:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iclk);
         #2;
      end
   endtask

   function automatic int frame_len(input cfg_t c);
      return (c.vb + c.nlines) * (c.hb0 + c.npix + c.hb1);
   endfunction

   // Reference: walk every position of the frame and write down what the outputs must show
   task automatic push_frame(input cfg_t c);
      exp_t e;
      int   ll, nl;
      bit   va, ha;
      ll = c.hb0 + c.npix + c.hb1;
      nl = c.vb + c.nlines;
      for (int ln = 0; ln < nl; ln++) begin
         for (int px = 0; px < ll; px++) begin
            va = (ln >= c.vb);
            ha = va && (px >= c.hb0) && (px < c.hb0 + c.npix);
            e.hact = ha;
            e.vact = va;
            e.dout = '0;
            if (ha) begin
               case (c.mode)
                  0: begin mdcnt = mdcnt + 12'd1; e.dout = mdcnt; end
                  1: e.dout = 12'(((ln - c.vb) % 64) * 64 + ((px - c.hb0) % 64));
                  2: e.dout = 12'hA5A;
                  default: begin mdcnt = mdcnt + 12'd1; e.dout = ~mdcnt; end
               endcase
            end
            e.fs   = (ln == 0) && (px == 0);
            e.fd   = (ln == nl - 1) && (px == ll - 1);
            e.busy = 1'b1;
            if (e.fd) mfcnt = mfcnt + 16'd1;
            e.fcnt = mfcnt;
            sb.push_back(e);
         end
      end
   endtask

   task automatic apply_cfg(input cfg_t c);
      npix = 12'(c.npix); nlines = 12'(c.nlines);
      vb = 8'(c.vb); hb0 = 8'(c.hb0); hb1 = 8'(c.hb1); mode = 2'(c.mode);
   endtask

   function automatic cfg_t mk(input int p, input int l, input int v, input int h0, input int h1,
                               input int m);
      cfg_t c;
      c.npix = p; c.nlines = l; c.vb = v; c.hb0 = h0; c.hb1 = h1; c.mode = m;
      return c;
   endfunction

   task automatic do_reset();
      en = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      mdcnt = '0;
      mfcnt = '0;
   endtask

   // Run the queued frames back to back; next config (or en drop) lands at a random mid-frame point
   task automatic run_plan(input bit sgl);
      int n, L, r;
      n = plan.size();
      foreach (plan[f]) push_frame(plan[f]);
      single = sgl;
      en = 1'b0;
      apply_cfg(plan[0]);
      tick(1);
      en = 1'b1;
      tick(1);
      for (int f = 0; f < n; f++) begin
         L = frame_len(plan[f]);
         if (f == 0 && L >= 2) begin
            r = $urandom_range(L, 2);
            tick(1);
            cmp("start_latency", 33'({busy, frame_start}), 33'(2'b11));
            tick(r - 2);
         end else begin
            r = $urandom_range(L, 1);
            tick(r - 1);
         end
         if (f == n - 1) begin
            if (!sgl) en = 1'b0;
         end else begin
            apply_cfg(plan[f + 1]);
         end
         tick(L - r + 1);
      end
      tick(3);
      cmp("drained", 33'(sb.size()), 33'(0));
      cmp("idle_after_run", 33'(busy), 33'(0));
      plan.delete();
   endtask

   always @(posedge iclk) rst_s <= rst;

   // Monitor: every busy cycle consumes one expected position; otherwise outputs must be quiet
   always @(negedge iclk) begin
      exp_t e;
      logic [32:0] got;
      got = {hact, vact, dout, frame_start, frame_done, busy, frame_cnt};
      if (rst_s) begin
         sb.delete();
         idle_fcnt = '0;
         cmp("reset_outputs", got, 33'(0));
      end else if (busy === 1'b1) begin
         if (sb.size() == 0) begin
            cmp("unexpected_busy", got, 33'(0));
         end else begin
            e = sb.pop_front();
            cmp("pixel", got, 33'(e));
            if (e.fd) idle_fcnt = e.fcnt;
         end
      end else begin
         cmp("idle_outputs", got, {17'(0), idle_fcnt});
      end
   end

   initial begin
      cfg_t c43, c;
      bit   sgl;
      int   nf;
      c43 = mk(4, 2, 1, 2, 1, 0);
      tick(3);
      do_reset();
      cmp("cnt_after_reset", 33'(frame_cnt), 33'(0));

      // Two continuous frames of the reference geometry
      plan.push_back(c43); plan.push_back(c43);
      run_plan(1'b0);
      cmp("cnt_two_frames", 33'(frame_cnt), 33'(mfcnt));

      // Single-shot with en held, then a fresh en edge
      do_reset();
      plan.push_back(c43);
      run_plan(1'b1);
      tick(10);
      cmp("single_cnt1", 33'({busy, frame_cnt}), 33'({1'b0, 16'd1}));
      plan.push_back(c43);
      run_plan(1'b1);
      cmp("single_cnt2", 33'(frame_cnt), 33'(16'd2));

      // npix changes mid-frame only take effect at the wrap
      plan.push_back(c43); plan.push_back(mk(6, 2, 1, 2, 1, 0));
      run_plan(1'b0);

      // Index pattern with no blanking at all
      plan.push_back(mk(3, 2, 0, 0, 0, 1));
      run_plan(1'b0);

      // Reset at line 1, pix 3 aborts the frame
      do_reset();
      push_frame(c43);
      single = 1'b0;
      apply_cfg(c43);
      tick(1);
      en = 1'b1;
      tick(1);
      tick(11);
      en = 1'b0;
      rst = 1'b1;
      tick(2);
      cmp("abort_outputs", 33'({hact, vact, dout, frame_start, frame_done, busy, frame_cnt}), 33'(0));
      rst = 1'b0;
      tick(2);
      mdcnt = '0;
      mfcnt = '0;
      plan.push_back(c43);
      run_plan(1'b0);

      // Zero pixels per line never starts
      apply_cfg(mk(0, 2, 1, 2, 1, 0));
      en = 1'b1;
      tick(20);
      cmp("npix0_idle", 33'({busy, hact, vact}), 33'(0));
      en = 1'b0;
      tick(2);

      // Randomized runs
      for (int t = 0; t < 14; t++) begin
         sgl = ($urandom_range(3, 0) == 0);
         nf = sgl ? 1 : int'($urandom_range(3, 1));
         for (int f = 0; f < nf; f++) begin
            c = mk($urandom_range(8, 1), $urandom_range(4, 1), $urandom_range(3, 0),
                   $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
            plan.push_back(c);
         end
         run_plan(sgl);
      end

      // Large mode-0 frame drives the data counter through its wrap
      plan.push_back(mk(64, 64, 0, 0, 0, 0));
      run_plan(1'b0);
      plan.push_back(mk(5, 2, 1, 1, 1, 3));
      run_plan(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
